sort4_ctrl: RTL and testbench
=============================

SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 SHALL have parameter DESCENDING, default 0; 0 = ascending output order, 1 = descending.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to sort din; sampled only in IDLE.
REQ-005 SHALL have port din  input  8  four 2-bit unsigned elements, element i at bits [2i+1:2i].
REQ-006 SHALL have port busy  output  1  high while a sort is in progress (CMP state).
REQ-007 SHALL have port done  output  1  one-cycle pulse: dout and swaps valid.
REQ-008 SHALL have port dout  output  8  sorted elements, same packing as din, element 0 first in sort order.
REQ-009 SHALL have port swaps  output  3  number of swaps performed by the last completed sort (0..6).

Function
REQ-010 SHALL implement FSM states IDLE, CMP, DONE.
REQ-011 In IDLE with start=1 at edge k: SHALL capture din into working regs r0..r3, clear pass/idx/swap counters, enter CMP.
REQ-012 In IDLE with start=0: SHALL stay in IDLE, holding dout and swaps.
REQ-013 In CMP: SHALL compare exactly one adjacent pair (r[idx], r[idx+1]) per cycle through a single comparator instance.
REQ-014 Swap condition: SHALL swap when r[idx] > r[idx+1] (DESCENDING=0) or r[idx] < r[idx+1] (DESCENDING=1); equal elements never swap.
REQ-015 On swap: SHALL exchange the pair in the same edge, increment swap count by 1, and set the pass-swapped flag.
REQ-016 Pass p (0..2) SHALL cover idx 0..(2-p); after the last idx of a pass, p increments, idx returns to 0, and the pass-swapped flag clears.
REQ-017 SHALL enter DONE after the final compare of pass 2, or at the end of any pass with pass-swapped flag clear (early exit).
REQ-018 Compare count n SHALL be 3 (input already sorted) to 6 (worst case); CMP occupies cycles k+1..k+n, done is high in cycle k+n+1.
REQ-019 On entering DONE: SHALL load dout from r0..r3 and swaps from the swap count; both hold until the next DONE or reset.
REQ-020 DONE SHALL last one cycle, then return to IDLE; done=1 only in DONE.
REQ-021 busy SHALL be 1 only in CMP; start asserted while busy or in DONE SHALL be ignored (not queued).
REQ-022 din changes after capture SHALL not affect the sort in progress.
REQ-023 swaps SHALL never exceed 6; counter width 3 bits, no wrap possible.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, dout=8'h00, swaps=0, done=0, busy=0, clear r0..r3 and counters, in any state including mid-sort.
REQ-025 rst SHALL have priority over start in the same cycle; an aborted sort SHALL produce no done pulse.

Structure
REQ-026 State encodings (IDLE, CMP, DONE), element width 2, element count 4 and max swap count 6 SHALL live in a shared package sort_pkg.
REQ-027 SHALL instantiate one sub-module cmp2 (combinational 2-bit comparator, inputs x,y, outputs gt, eq, lt) as the only magnitude comparator.
REQ-028 The swap decision SHALL use gt (ascending) or lt (descending) from cmp2; no other comparison logic.

Verification
REQ-029 Reset: rst held 2 cycles mid-sort -> IDLE next cycle, dout=8'h00, swaps=0, no done pulse.
REQ-030 Already sorted: din={3,2,1,0} packed as 8'hE4 (e0=0,e1=1,e2=2,e3=3), start at k -> done at k+4, dout=8'hE4, swaps=0.
REQ-031 Reversed: elements e0..e3 = 3,2,1,0 (din=8'h1B) -> done at k+7, dout=8'hE4, swaps=6.
REQ-032 Duplicates: elements 2,0,2,0 (din=8'h22) -> dout elements 0,0,2,2 (8'hA0), swaps=3, done at k+7.
REQ-033 start held high throughout sort of 8'h1B, din changed mid-sort -> result unchanged, exactly one done, new sort begins from IDLE after DONE.
REQ-034 DESCENDING=1, din=8'hE4 -> dout elements 3,2,1,0 (8'h1B), swaps=6, done at k+7.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the 4-element bubble sorter: state encoding,
// element geometry and the per-pass compare range.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ELEM_W    = 2;
  localparam int ELEM_N    = 4;
  localparam int MAX_SWAPS = 6;
  localparam int SWAP_W    = 3;

  typedef logic [ELEM_W-1:0] elem_t;

  // Highest pair index compared in a pass: pass 0 covers 0..2, pass 2 only 0.
  function automatic logic [1:0] last_idx_f(input logic [1:0] pass);
    return 2'd2 - pass;
  endfunction

endpackage

// File: rtl/sort4_ctrl_cmp2.sv
// Combinational magnitude comparator for two 2-bit unsigned elements.
// This is the only place in the sorter where element magnitudes are compared.
module cmp2
  import sort_pkg::*;
(
  input  elem_t x,
  input  elem_t y,
  output logic  gt,
  output logic  eq,
  output logic  lt
);

  // Exactly one of gt/eq/lt is high for any input pair.
  always_comb begin
    gt = (x > y);
    eq = (x == y);
    lt = (x < y);
  end

endmodule

// File: rtl/sort4_ctrl.sv
// Sequential bubble sorter for four 2-bit elements. One adjacent pair is
// compared per cycle through a single cmp2; a pass without any swap ends the
// sort early. Result and swap count are registered and held until the next
// completed sort or reset.
module sort4_ctrl
  import sort_pkg::*;
#(
  parameter int DESCENDING = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic [2:0] swaps
);

  state_t              state_r, state_n;
  elem_t               r_r [ELEM_N];
  elem_t               r_n [ELEM_N];
  logic [1:0]          pass_r, pass_n;
  logic [1:0]          idx_r, idx_n;
  logic [SWAP_W-1:0]   swap_cnt_r, swap_cnt_n;
  logic                pass_swapped_r, pass_swapped_n;
  logic [7:0]          dout_r;
  logic [SWAP_W-1:0]   swaps_r;
  logic                busy_r, done_r;

  elem_t               a_s, b_s;
  logic                gt_s, eq_s, lt_s;
  logic                swap_s;
  logic                load_out_s;
  logic [7:0]          dout_n_s;

  // Route the currently addressed adjacent pair to the shared comparator.
  always_comb begin
    a_s = r_r[0];
    b_s = r_r[1];
    case (idx_r)
      2'd0: begin a_s = r_r[0]; b_s = r_r[1]; end
      2'd1: begin a_s = r_r[1]; b_s = r_r[2]; end
      2'd2: begin a_s = r_r[2]; b_s = r_r[3]; end
      default: begin a_s = r_r[0]; b_s = r_r[1]; end
    endcase
  end

  cmp2 u_cmp (
    .x  (a_s),
    .y  (b_s),
    .gt (gt_s),
    .eq (eq_s),
    .lt (lt_s)
  );

  // Swap decision from the comparator flags; ties never swap, so the sort is stable.
  always_comb begin
    if (DESCENDING != 0) begin
      swap_s = lt_s && !eq_s;
    end else begin
      swap_s = gt_s && !eq_s;
    end
  end

  // Next-state, working-register and counter update for the sort FSM.
  always_comb begin
    state_n        = state_r;
    r_n            = r_r;
    pass_n         = pass_r;
    idx_n          = idx_r;
    swap_cnt_n     = swap_cnt_r;
    pass_swapped_n = pass_swapped_r;
    load_out_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          r_n[0]         = din[1:0];
          r_n[1]         = din[3:2];
          r_n[2]         = din[5:4];
          r_n[3]         = din[7:6];
          pass_n         = 2'd0;
          idx_n          = 2'd0;
          swap_cnt_n     = 3'd0;
          pass_swapped_n = 1'b0;
          state_n        = ST_CMP;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (swap_s) begin
          case (idx_r)
            2'd0: begin r_n[0] = b_s; r_n[1] = a_s; end
            2'd1: begin r_n[1] = b_s; r_n[2] = a_s; end
            2'd2: begin r_n[2] = b_s; r_n[3] = a_s; end
            default: begin r_n[0] = r_r[0]; end
          endcase
          swap_cnt_n     = swap_cnt_r + 3'd1;
          pass_swapped_n = 1'b1;
        end else begin
          swap_cnt_n = swap_cnt_r;
        end
        if (idx_r == last_idx_f(pass_r)) begin
          // End of pass: finish after pass 2 or when this pass moved nothing.
          if ((pass_r == 2'd2) || !(pass_swapped_r || swap_s)) begin
            state_n    = ST_DONE;
            load_out_s = 1'b1;
          end else begin
            pass_n         = pass_r + 2'd1;
            idx_n          = 2'd0;
            pass_swapped_n = 1'b0;
          end
        end else begin
          idx_n = idx_r + 2'd1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Pack the post-compare working registers into the output layout.
  always_comb begin
    dout_n_s = {r_n[3], r_n[2], r_n[1], r_n[0]};
  end

  // State, working registers and registered outputs; reset aborts any sort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      r_r[0]         <= 2'd0;
      r_r[1]         <= 2'd0;
      r_r[2]         <= 2'd0;
      r_r[3]         <= 2'd0;
      pass_r         <= 2'd0;
      idx_r          <= 2'd0;
      swap_cnt_r     <= 3'd0;
      pass_swapped_r <= 1'b0;
      dout_r         <= 8'h00;
      swaps_r        <= 3'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_n;
      r_r            <= r_n;
      pass_r         <= pass_n;
      idx_r          <= idx_n;
      swap_cnt_r     <= swap_cnt_n;
      pass_swapped_r <= pass_swapped_n;
      if (load_out_s) begin
        dout_r  <= dout_n_s;
        swaps_r <= swap_cnt_n;
      end else begin
        dout_r  <= dout_r;
        swaps_r <= swaps_r;
      end
      busy_r <= (state_n == ST_CMP);
      done_r <= (state_n == ST_DONE);
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign dout  = dout_r;
  assign swaps = swaps_r;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Bench for sort4_ctrl: an ascending and a descending instance are driven
// with the same stimulus and checked against a reference computed from
// element histograms, inversion counts and bubble-pass depth.
module tb_sort4_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] din;
  logic       busy_a, done_a, busy_d, done_d;
  logic [7:0] dout_a, dout_d;
  logic [2:0] swaps_a, swaps_d;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout_a; int sw_a; int n_a;
    logic [7:0] dout_d; int sw_d; int n_d;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  sort4_ctrl #(.DESCENDING(0)) u_asc (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy_a), .done(done_a), .dout(dout_a), .swaps(swaps_a)
  );

  sort4_ctrl #(.DESCENDING(1)) u_desc (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy_d), .done(done_d), .dout(dout_d), .swaps(swaps_d)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: sorted output from a histogram, swaps as the inversion count,
  // compare count from how many bubble passes are needed plus a clean pass.
  function automatic void ref_sort(input logic [7:0] d, input bit desc,
                                   output logic [7:0] o, output int sw, output int n);
    int e [4];
    int hist [4];
    int pos, need, cnt, passes;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    for (int i = 0; i < 4; i++) begin
      e[i] = int'(d[2*i +: 2]);
      hist[e[i]]++;
    end
    o = 8'h00;
    pos = 0;
    for (int k = 0; k < 4; k++) begin
      int v;
      v = desc ? 3 - k : k;
      for (int c = 0; c < hist[v]; c++) begin
        o[2*pos +: 2] = 2'(v);
        pos++;
      end
    end
    sw = 0;
    need = 0;
    for (int j = 0; j < 4; j++) begin
      cnt = 0;
      for (int i = 0; i < j; i++) begin
        if (desc ? (e[i] < e[j]) : (e[i] > e[j])) cnt++;
      end
      sw += cnt;
      if (cnt > need) need = cnt;
    end
    passes = (need >= 3) ? 3 : need + 1;
    n = 0;
    for (int p = 0; p < passes; p++) n += 3 - p;
  endfunction

  // One sort on both instances; hold keeps start high and scrambles din mid-sort.
  task automatic run_one(input logic [7:0] v, input bit hold,
                         input logic [7:0] eo_a, input int es_a, input int en_a,
                         input logic [7:0] eo_d, input int es_d, input int en_d);
    int ca, cd, pa, pd, last;
    ca = -1; cd = -1; pa = 0; pd = 0;
    last = ((en_a > en_d) ? en_a : en_d) + 2;
    @(negedge clk);
    din   = v;
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_a_after_start", busy_a, 1);
    check("busy_d_after_start", busy_d, 1);
    if (!hold) start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (hold) din = 8'($urandom);
      if (done_a && (!hold || c <= en_a + 1)) begin
        pa++;
        if (ca < 0) begin
          ca = c;
          check("dout_a", dout_a, eo_a);
          check("swaps_a", swaps_a, es_a);
        end
      end
      if (done_d && (!hold || c <= en_d + 1)) begin
        pd++;
        if (cd < 0) begin
          cd = c;
          check("dout_d", dout_d, eo_d);
          check("swaps_d", swaps_d, es_d);
        end
      end
      if (hold && c == en_a + 2) check("restart_busy_a", busy_a, 1);
      if (hold && c == en_d + 2) check("restart_busy_d", busy_d, 1);
    end
    check("latency_a", ca, en_a);
    check("latency_d", cd, en_d);
    check("done_pulses_a", pa, 1);
    check("done_pulses_d", pd, 1);
    start = 1'b0;
    if (hold) begin
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] oa, od;
    logic [7:0] v;
    int sa, sd, na, nd, dn;

    vecs[0] = '{8'hE4, 8'hE4, 0, 3, 8'h1B, 6, 6};
    vecs[1] = '{8'h1B, 8'hE4, 6, 6, 8'h1B, 0, 3};
    vecs[2] = '{8'h22, 8'hA0, 3, 6, 8'h0A, 1, 5};

    rst = 1'b1; start = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_dout", dout_a, 0);
    check("rst_swaps", swaps_a, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_one(vecs[i].din, 1'b0, vecs[i].dout_a, vecs[i].sw_a, vecs[i].n_a,
              vecs[i].dout_d, vecs[i].sw_d, vecs[i].n_d);
      check("idle_hold_dout_a", dout_a, vecs[i].dout_a);
    end

    // Mid-sort reset: outputs clear, start loses to reset, no done afterwards.
    @(negedge clk); din = 8'h1B; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy_a", busy_a, 0);
    check("midrst_done_a", done_a, 0);
    check("midrst_dout_a", dout_a, 0);
    check("midrst_swaps_a", swaps_a, 0);
    check("midrst_dout_d", dout_d, 0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check("rst_over_start_busy_a", busy_a, 0);
    check("rst_over_start_busy_d", busy_d, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done_a || done_d) dn++;
    end
    check("no_done_after_abort", dn, 0);

    // start held through the sort with din scrambled mid-sort.
    ref_sort(8'h1B, 1'b0, oa, sa, na);
    ref_sort(8'h1B, 1'b1, od, sd, nd);
    run_one(8'h1B, 1'b1, oa, sa, na, od, sd, nd);

    for (int i = 0; i < 24; i++) begin
      v = 8'($urandom);
      ref_sort(v, 1'b0, oa, sa, na);
      ref_sort(v, 1'b1, od, sd, nd);
      run_one(v, 1'b0, oa, sa, na, od, sd, nd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
